pc_branch_unit: RTL and testbench
=================================

Name: pc_branch_unit

Overview:
- Program-counter and branch-resolution stage directly downstream of the ALU.
- Consumes the ALU's compare result (compres) and ALU out (jump target); produces the fetch PC for the next instruction.
- Sequences branches through a one-cycle resolve state, because compres settles during the branch instruction's cycle and is sampled the following cycle.
- Handles jump, halt, external stall and pipeline flush.

Parameters:
PC_W, 16, width of the program counter and of jump_target.
OFF_W, 8, width of the signed branch offset.
RESET_PC, 0, PC value loaded on reset.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
stall  input  1  freeze all state this cycle; highest priority after reset.
is_branch  input  1  current instruction is a conditional branch.
is_jump  input  1  current instruction is an unconditional jump to jump_target.
is_halt  input  1  current instruction is halt.
resume  input  1  leave HALT state.
offset  input  OFF_W  signed branch displacement in instructions.
jump_target  input  PC_W  absolute target taken from ALU out.
compres  input  1  ALU compare result; sampled only in RESOLVE.
pc  output  PC_W  current fetch address (registered).
busy  output  1  high in RESOLVE; upstream must hold the instruction.
flush  output  1  one-cycle pulse when the PC was redirected; younger instruction is discarded.
halted  output  1  high in HALT.

Behaviour:
- Reset (async, at any time, including mid-RESOLVE):
  - pc = RESET_PC, state = RUN.
  - busy = 0, flush = 0, halted = 0.
  - Pending branch is dropped.
- States: RUN, RESOLVE, HALT. The state register and pc update only when stall = 0.
- flush is registered: high exactly on the cycle after a redirecting edge, low otherwise.
  - Forced 0 on any cycle where stall = 1; a stalled pulse is not lost, it appears on the first unstalled cycle.
- RUN priority, evaluated per cycle: is_halt > is_jump > is_branch > sequential.
  - is_halt: pc holds; next state HALT.
  - is_jump: pc <= jump_target; flush next cycle; stay in RUN.
  - is_branch: latch offset and pc; pc holds; next state RESOLVE.
  - Otherwise: pc <= pc + 1.
- RESOLVE (busy = 1):
  - is_* inputs are ignored.
  - compres = 1: pc <= latched_pc + sign_extend(latched_offset); flush next cycle.
  - compres = 0: pc <= latched_pc + 1; no flush.
  - Next state RUN. Branch latency is 2 cycles from issue to new PC.
- HALT (halted = 1):
  - pc holds.
  - resume = 1: pc <= pc + 1, next state RUN.
  - reset also exits.
- Arithmetic:
  - All PC math is modulo 2^PC_W; wrap-around is silent (0xFFFF + 1 = 0x0000; 0x0002 + (-4) = 0xFFFE).
  - Offset is sign-extended from OFF_W to PC_W.
- Simultaneous events:
  - Multiple is_* flags set together resolve by the priority above; the lower-priority flags are ignored.
  - stall = 1 during RESOLVE delays the compres sample to the first unstalled cycle.

Optional Feature:
- Macro PC_BRANCH_STATS_EN.
- When defined:
  - Adds outputs br_taken_cnt [15:0] and br_total_cnt [15:0].
  - br_total_cnt increments on each RESOLVE exit.
  - br_taken_cnt increments on each RESOLVE exit with compres = 1.
  - Both saturate at 0xFFFF and reset to 0.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- reset, then 3 idle cycles -> pc = 0,1,2,3; flush = 0; busy = 0.
- At pc = 0x0010, is_branch with offset = 0xFC and compres = 1 in the next cycle -> busy = 1 for 1 cycle; pc becomes 0x000C; flush pulses once.
- Same branch with compres = 0 -> pc becomes 0x0011; flush stays 0.
- is_jump with jump_target = 0x1234 and is_branch also set -> pc = 0x1234 next cycle; no RESOLVE entered; flush pulses.
- is_halt at pc = 0x0005, 4 cycles idle, then resume -> halted = 1 and pc = 0x0005 while halted; then pc = 0x0006 and halted = 0.
- Assert reset during RESOLVE, and separately stall for 2 cycles during RESOLVE -> reset returns pc = RESET_PC in RUN immediately; stall keeps busy = 1 and pc frozen until release, then the branch resolves normally.
- Stats build: 3 branches (taken, not, taken) -> br_total_cnt = 3, br_taken_cnt = 2.

Source files
------------

// File: rtl/pc_branch_unit.sv
// Program counter and branch resolution stage fed by the ALU compare result and jump target.
// Optional branch statistics counters are enabled with `define PC_BRANCH_STATS_EN.
module pc_branch_unit #(
    parameter int PC_W = 16,
    parameter int OFF_W = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              is_branch,
    input  logic              is_jump,
    input  logic              is_halt,
    input  logic              resume,
    input  logic [OFF_W-1:0]  offset,
    input  logic [PC_W-1:0]   jump_target,
    input  logic              compres,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              flush,
    output logic              halted
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [15:0]       br_taken_cnt,
    output logic [15:0]       br_total_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_RESOLVE,
        ST_HALT
    } state_t;

    state_t             state_reg, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [PC_W-1:0]    lat_pc_reg, lat_pc_next;
    logic [OFF_W-1:0]   lat_off_reg, lat_off_next;
    logic               flush_reg;
    logic               redirect;
    logic [PC_W-1:0]    off_ext;

    assign off_ext = {{(PC_W-OFF_W){lat_off_reg[OFF_W-1]}}, lat_off_reg};

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        lat_pc_next  = lat_pc_reg;
        lat_off_next = lat_off_reg;
        redirect     = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (is_halt) begin
                    state_next = ST_HALT;
                end else if (is_jump) begin
                    pc_next  = jump_target;
                    redirect = 1'b1;
                end else if (is_branch) begin
                    lat_pc_next  = pc_reg;
                    lat_off_next = offset;
                    state_next   = ST_RESOLVE;
                end else begin
                    pc_next = pc_reg + PC_W'(1);
                end
            end
            ST_RESOLVE: begin
                // compres belongs to the branch issued last cycle; upstream flags are ignored here
                state_next = ST_RUN;
                if (compres) begin
                    pc_next  = lat_pc_reg + off_ext;
                    redirect = 1'b1;
                end else begin
                    pc_next = lat_pc_reg + PC_W'(1);
                end
            end
            ST_HALT: begin
                if (resume) begin
                    pc_next    = pc_reg + PC_W'(1);
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_RUN;
            pc_reg      <= RESET_PC;
            lat_pc_reg  <= '0;
            lat_off_reg <= '0;
            flush_reg   <= 1'b0;
        end else if (!stall) begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            lat_pc_reg  <= lat_pc_next;
            lat_off_reg <= lat_off_next;
            flush_reg   <= redirect;
        end
    end

    // A pending flush is held through stalls and only shown on an unstalled cycle
    assign flush  = flush_reg & ~stall;
    assign pc     = pc_reg;
    assign busy   = (state_reg == ST_RESOLVE);
    assign halted = (state_reg == ST_HALT);

`ifdef PC_BRANCH_STATS_EN
    logic resolve_exit;
    assign resolve_exit = (state_reg == ST_RESOLVE) && !stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            br_total_cnt <= '0;
            br_taken_cnt <= '0;
        end else if (resolve_exit) begin
            if (br_total_cnt != 16'hFFFF)
                br_total_cnt <= br_total_cnt + 16'd1;
            if (compres && br_taken_cnt != 16'hFFFF)
                br_taken_cnt <= br_taken_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed, table-driven bench for pc_branch_unit plus hand-written reset/stall sequences.
// Build with +define+PC_BRANCH_STATS_EN to also check the branch counters.
module tb_pc_branch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall, is_branch, is_jump, is_halt, resume, compres;
    logic [7:0]  offset;
    logic [15:0] jump_target;
    logic [15:0] pc;
    logic        busy, flush, halted;
`ifdef PC_BRANCH_STATS_EN
    logic [15:0] br_taken_cnt, br_total_cnt;
`endif

    always #5 clock = ~clock;

    pc_branch_unit #(.PC_W(16), .OFF_W(8), .RESET_PC(16'h0000)) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .is_branch   (is_branch),
        .is_jump     (is_jump),
        .is_halt     (is_halt),
        .resume      (resume),
        .offset      (offset),
        .jump_target (jump_target),
        .compres     (compres),
        .pc          (pc),
        .busy        (busy),
        .flush       (flush),
        .halted      (halted)
`ifdef PC_BRANCH_STATS_EN
        ,
        .br_taken_cnt(br_taken_cnt),
        .br_total_cnt(br_total_cnt)
`endif
    );

    typedef struct {
        logic        st, br, jp, ht, rs, cr;
        logic [7:0]  off;
        logic [15:0] tgt;
        logic [15:0] e_pc;
        logic        e_busy, e_flush, e_halted;
    } vec_t;

    vec_t vq[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic st, br, jp, ht, rs, cr, input logic [7:0] off,
                       input logic [15:0] tgt, input logic [15:0] e_pc,
                       input logic e_busy, e_flush, e_halted);
        vec_t v;
        v.st = st; v.br = br; v.jp = jp; v.ht = ht; v.rs = rs; v.cr = cr;
        v.off = off; v.tgt = tgt; v.e_pc = e_pc;
        v.e_busy = e_busy; v.e_flush = e_flush; v.e_halted = e_halted;
        vq.push_back(v);
    endtask

    task automatic drive(input logic st, br, jp, ht, rs, cr, input logic [7:0] off,
                         input logic [15:0] tgt);
        stall = st; is_branch = br; is_jump = jp; is_halt = ht; resume = rs;
        compres = cr; offset = off; jump_target = tgt;
    endtask

    task automatic check_outs(input string tag, input logic [15:0] e_pc,
                              input logic e_busy, e_flush, e_halted);
        check({tag, " pc"}, 32'(pc), 32'(e_pc));
        check({tag, " busy"}, 32'(busy), 32'(e_busy));
        check({tag, " flush"}, 32'(flush), 32'(e_flush));
        check({tag, " halted"}, 32'(halted), 32'(e_halted));
    endtask

    initial begin
        //   st br jp ht rs cr  off     tgt        pc      busy fl  hlt
        add(0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0001, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0002, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0003, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 8'h00, 16'h0010, 16'h0010, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 8'hFC, 16'h0000, 16'h0010, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 8'h00, 16'h0000, 16'h000C, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h000D, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 8'h00, 16'h0010, 16'h0010, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 8'hFC, 16'h0000, 16'h0010, 1, 0, 0);
        add(0, 0, 1, 1, 0, 0, 8'h00, 16'h5555, 16'h0011, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 8'h10, 16'h1234, 16'h1234, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h1235, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 8'h00, 16'h4444, 16'h1235, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h1235, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 8'h00, 16'h0000, 16'h1236, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 8'h00, 16'h0004, 16'h0004, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0005, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 8'h00, 16'h0000, 16'h0005, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0005, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 8'h00, 16'h0000, 16'h0006, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 8'h00, 16'hFFFF, 16'hFFFF, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 8'h80, 16'h0000, 16'h0000, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 8'h00, 16'h0000, 16'hFF80, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 8'h00, 16'h0002, 16'h0002, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 8'hFC, 16'h0000, 16'h0002, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 8'h00, 16'h0000, 16'hFFFE, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 8'h00, 16'h0020, 16'h0020, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 8'h7F, 16'h0000, 16'h0020, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0020, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0020, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 8'h00, 16'h0000, 16'h009F, 0, 1, 0);
        add(1, 0, 1, 0, 0, 0, 8'h00, 16'h7777, 16'h009F, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h00A0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 8'h00, 16'h0000, 16'h00A0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 8'h00, 16'h0000, 16'h00A0, 0, 0, 1);
        add(1, 0, 0, 0, 1, 0, 8'h00, 16'h0000, 16'h00A0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 8'h00, 16'h0000, 16'h00A1, 0, 0, 0);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 8'h00, 16'h0000);
        @(posedge clock); #1;
        check_outs("reset", 16'h0000, 0, 0, 0);
        $display("reset: pc=%h busy=%b flush=%b halted=%b", pc, busy, flush, halted);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].st, vq[i].br, vq[i].jp, vq[i].ht, vq[i].rs, vq[i].cr, vq[i].off, vq[i].tgt);
            @(posedge clock); #1;
            check_outs($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_busy, vq[i].e_flush, vq[i].e_halted);
            $display("vec%0d: pc=%h busy=%b flush=%b halted=%b", i, pc, busy, flush, halted);
        end

        // flush pulse raised just before a stall must survive it
        drive(0, 0, 1, 0, 0, 0, 8'h00, 16'h0300);
        @(posedge clock); #1;
        check_outs("sflush jump", 16'h0300, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 8'h00, 16'h0000);
        #1;
        check("sflush masked", 32'(flush), 32'd0);
        @(posedge clock); #1;
        check_outs("sflush hold", 16'h0300, 0, 0, 0);
        stall = 1'b0;
        #1;
        check("sflush release", 32'(flush), 32'd1);
        @(posedge clock); #1;
        check_outs("sflush done", 16'h0301, 0, 0, 0);
        $display("stalled flush: pc=%h flush=%b", pc, flush);

        // asynchronous reset in the middle of RESOLVE drops the branch
        drive(0, 1, 0, 0, 0, 0, 8'h10, 16'h0000);
        @(posedge clock); #1;
        check_outs("rstres issue", 16'h0301, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 8'h00, 16'h0000);
        #2 reset = 1'b1;
        #1;
        check_outs("rstres async", 16'h0000, 0, 0, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 8'h00, 16'h0000);
        @(posedge clock); #1;
        check_outs("rstres after", 16'h0001, 0, 0, 0);
        $display("reset in resolve: pc=%h busy=%b", pc, busy);

        // three branches: taken, not taken, taken
        drive(0, 1, 0, 0, 0, 0, 8'h04, 16'h0000);
        @(posedge clock); #1;
        check_outs("br1 issue", 16'h0001, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 8'h00, 16'h0000);
        @(posedge clock); #1;
        check_outs("br1 taken", 16'h0005, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 0, 8'h04, 16'h0000);
        @(posedge clock); #1;
        drive(0, 0, 0, 0, 0, 0, 8'h00, 16'h0000);
        @(posedge clock); #1;
        check_outs("br2 not", 16'h0006, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 8'h04, 16'h0000);
        @(posedge clock); #1;
        drive(0, 0, 0, 0, 0, 1, 8'h00, 16'h0000);
        @(posedge clock); #1;
        check_outs("br3 taken", 16'h000A, 0, 1, 0);
        $display("branch trio: pc=%h", pc);
`ifdef PC_BRANCH_STATS_EN
        check("br_total_cnt", 32'(br_total_cnt), 32'd3);
        check("br_taken_cnt", 32'(br_taken_cnt), 32'd2);
        $display("stats: total=%0d taken=%0d", br_total_cnt, br_taken_cnt);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
